// File: rtl/bus_sequencer_pkg.sv
// Shared types and constants for the fetch/execute bus sequencer.
// No logic; consumed by the sequencer and its decoder.
// Bus source indices, opcode range and instruction field layout.
package bus_sequencer_pkg;

    typedef enum logic [2:0] {IDLE, T0, T1, MEMW, T2, T3, T4, T5} state_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [14:0] imm;
    } instr_t;

    // Bus source indices above the sixteen register outputs
    localparam int BUS_HI     = 16;
    localparam int BUS_LO     = 17;
    localparam int BUS_ZHI    = 18;
    localparam int BUS_ZLO    = 19;
    localparam int BUS_PC     = 20;
    localparam int BUS_MDR    = 21;
    localparam int BUS_INPORT = 22;
    localparam int BUS_C      = 23;

    localparam logic [4:0] OP_ADD = 5'd3;
    localparam logic [4:0] OP_SUB = 5'd4;
    localparam logic [4:0] OP_AND = 5'd5;
    localparam logic [4:0] OP_OR  = 5'd6;
    localparam logic [4:0] OP_SHR = 5'd7;
    localparam logic [4:0] OP_SHL = 5'd8;
    localparam logic [4:0] OP_ROR = 5'd9;
    localparam logic [4:0] OP_ROL = 5'd10;

    function automatic logic is_alu_op(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_ROL);
    endfunction

endpackage

// File: rtl/bus_sequencer_reg_decoder_4to16.sv
// 4-bit register index to 16-bit one-hot select, gated by enable.
// Latency: combinational.
// Backpressure: none.
module reg_decoder_4to16 (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    assign onehot = en ? (16'b1 << idx) : 16'b0;

endmodule

// File: rtl/bus_sequencer.sv
// Fetch/execute control sequencer driving one-hot bus selects and datapath strobes.
// Latency: start to done is 7 cycles plus one per MEMW wait cycle.
// Backpressure: stalls in MEMW until mem_ready; start ignored while busy except in T5.
module bus_sequencer
    import bus_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [23:0] bus_sel,
    output logic [15:0] r_in,
    output logic        pc_in,
    output logic        ir_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        y_in,
    output logic        z_in,
    output logic        read,
    output logic        inc_pc,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_t      state_q, state_d;
    instr_t      instr;
    logic [7:0]  bus_hi;
    logic [15:0] bus_lo;
    logic        lo_en;
    logic [3:0]  lo_idx;
    logic        rin_en;
    logic        unused_imm;

    assign instr      = instr_t'(ir);
    assign unused_imm = ^instr.imm;

    reg_decoder_4to16 u_bus_dec (
        .idx    (lo_idx),
        .en     (lo_en),
        .onehot (bus_lo)
    );

    reg_decoder_4to16 u_rin_dec (
        .idx    (instr.ra),
        .en     (rin_en),
        .onehot (r_in)
    );

    assign bus_sel = {bus_hi, bus_lo};

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        bus_hi  = '0;
        lo_en   = 1'b0;
        lo_idx  = instr.rb;
        rin_en  = 1'b0;
        pc_in   = 1'b0;
        ir_in   = 1'b0;
        mar_in  = 1'b0;
        mdr_in  = 1'b0;
        y_in    = 1'b0;
        z_in    = 1'b0;
        read    = 1'b0;
        inc_pc  = 1'b0;
        alu_op  = '0;
        done    = 1'b0;
        illegal = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: if (start) state_d = T0;
            T0: begin
                bus_hi[BUS_PC - 16] = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                state_d = T1;
            end
            T1: begin
                bus_hi[BUS_ZLO - 16] = 1'b1;
                pc_in   = 1'b1;
                read    = 1'b1;
                state_d = MEMW;
            end
            MEMW: begin
                read   = 1'b1;
                mdr_in = mem_ready;
                if (mem_ready) state_d = T2;
            end
            T2: begin
                bus_hi[BUS_MDR - 16] = 1'b1;
                ir_in   = 1'b1;
                state_d = T3;
            end
            T3: begin
                if (is_alu_op(instr.opcode)) begin
                    lo_en   = 1'b1;
                    lo_idx  = instr.rb;
                    y_in    = 1'b1;
                    state_d = T4;
                end else begin
                    illegal = 1'b1;
                    state_d = IDLE;
                end
            end
            T4: begin
                lo_en   = 1'b1;
                lo_idx  = instr.rc;
                z_in    = 1'b1;
                // Legal opcodes 3..10 all have bit 4 clear, so the low nibble suffices
                alu_op  = instr.opcode[3:0] - 4'd3;
                state_d = T5;
            end
            T5: begin
                bus_hi[BUS_ZLO - 16] = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                state_d = start ? T0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed self-checking bench for bus_sequencer with hand-computed expectations.
module tb_bus_sequencer;

    logic        clock, clear, start, mem_ready;
    logic [31:0] ir;
    logic [23:0] bus_sel;
    logic [15:0] r_in;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, read, inc_pc;
    logic [3:0]  alu_op;
    logic        busy, done, illegal;

    int n_checks = 0;
    int n_errors = 0;
    int onehot_bad = 0;

    localparam logic [7:0] S_PC = 8'h80, S_IR = 8'h40, S_MAR = 8'h20, S_MDR = 8'h10;
    localparam logic [7:0] S_Y = 8'h08, S_Z = 8'h04, S_RD = 8'h02, S_INC = 8'h01;
    localparam logic [2:0] ST_B = 3'b100, ST_D = 3'b010, ST_I = 3'b001;

    bus_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .bus_sel(bus_sel), .r_in(r_in), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in),
        .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .read(read), .inc_pc(inc_pc),
        .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
    );

    wire [7:0]  strb    = {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, read, inc_pc};
    wire [2:0]  stat    = {busy, done, illegal};
    wire [54:0] out_all = {bus_sel, r_in, strb, alu_op, stat};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock)
        if ($countones(bus_sel) > 1 || $countones(r_in) > 1) onehot_bad++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input logic [23:0] bs, input logic [15:0] ri,
                               input logic [7:0] st, input logic [3:0] op, input logic [2:0] sts);
        check({tag, ".bus_sel"}, 64'(bus_sel), 64'(bs));
        check({tag, ".r_in"},    64'(r_in),    64'(ri));
        check({tag, ".strobes"}, 64'(strb),    64'(st));
        check({tag, ".alu_op"},  64'(alu_op),  64'(op));
        check({tag, ".status"},  64'(stat),    64'(sts));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    // Pulse start for one edge; leaves the DUT in T0
    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advances until done is seen; cyc counts cycles since T0 (T0 = 1)
    task automatic run_to_done(inout int cyc);
        int guard = 0;
        while (!done && guard < 40) begin
            tick();
            cyc++;
            guard++;
        end
    endtask

    initial begin
        int cyc;
        int drops;
        int ndone;
        int last_done;
        logic [4:0] bad_ops [4];
        bad_ops[0] = 5'd15; bad_ops[1] = 5'd2; bad_ops[2] = 5'd11; bad_ops[3] = 5'd0;

        clear = 1'b1; start = 1'b0; mem_ready = 1'b1; ir = '0;
        #3;
        check("reset_initial", 64'(out_all), 64'd0);
        start = 1'b1;
        #20;
        check("reset_start_held", 64'(out_all), 64'd0);
        start = 1'b0;
        tick();
        clear = 1'b0;
        tick();
        check("idle_without_start", 64'(out_all), 64'd0);

        // add R1,R2,R3 with memory ready immediately
        ir = mk_ir(5'd3, 4'd1, 4'd2, 4'd3);
        kick();
        expect_outs("add.T0", 24'h100000, 16'h0, S_MAR | S_INC | S_Z, 4'd0, ST_B);
        tick(); expect_outs("add.T1", 24'h080000, 16'h0, S_PC | S_RD, 4'd0, ST_B);
        tick(); expect_outs("add.MEMW", 24'h0, 16'h0, S_RD | S_MDR, 4'd0, ST_B);
        tick(); expect_outs("add.T2", 24'h200000, 16'h0, S_IR, 4'd0, ST_B);
        tick(); expect_outs("add.T3", 24'h000004, 16'h0, S_Y, 4'd0, ST_B);
        tick(); expect_outs("add.T4", 24'h000008, 16'h0, S_Z, 4'd0, ST_B);
        tick(); expect_outs("add.T5", 24'h080000, 16'h0002, 8'h0, 4'd0, ST_B | ST_D);
        tick(); check("add.idle", 64'(out_all), 64'd0);

        // rol R15,R0,R14: extreme register indices and top alu code
        ir = mk_ir(5'd10, 4'd15, 4'd0, 4'd14);
        kick();
        repeat (4) tick();
        expect_outs("rol.T3", 24'h000001, 16'h0, S_Y, 4'd0, ST_B);
        tick(); expect_outs("rol.T4", 24'h004000, 16'h0, S_Z, 4'd7, ST_B);
        tick(); expect_outs("rol.T5", 24'h080000, 16'h8000, 8'h0, 4'd0, ST_B | ST_D);
        tick();

        // opcodes outside 3..10 abort in T3
        foreach (bad_ops[k]) begin
            ir = mk_ir(bad_ops[k], 4'd5, 4'd6, 4'd7);
            kick();
            repeat (4) tick();
            expect_outs($sformatf("illegal%0d.T3", bad_ops[k]), 24'h0, 16'h0, 8'h0, 4'd0, ST_B | ST_I);
            tick();
            check($sformatf("illegal%0d.after", bad_ops[k]), 64'(out_all), 64'd0);
        end

        // memory wait: ready low for 5 MEMW cycles
        ir = mk_ir(5'd4, 4'd2, 4'd3, 4'd4);
        kick();
        cyc = 1;
        mem_ready = 1'b0;
        tick(); cyc++;
        for (int i = 0; i < 5; i++) begin
            tick(); cyc++;
            check($sformatf("wait%0d.read_mdr", i), 64'({read, mdr_in, busy}), 64'(3'b101));
        end
        tick(); cyc++;
        mem_ready = 1'b1;
        #1;
        check("wait.ready_cycle", 64'({read, mdr_in, bus_sel}), 64'({2'b11, 24'h0}));
        run_to_done(cyc);
        check("wait.done_cycle", 64'(cyc), 64'd12);
        check("wait.done_seen", 64'(done), 64'd1);
        tick();

        // asynchronous clear while stalled in MEMW
        mem_ready = 1'b0;
        kick();
        tick(); tick(); tick();
        check("clr.pre_read", 64'(read), 64'd1);
        #2 clear = 1'b1;
        #1;
        check("clr.async", 64'(out_all), 64'd0);
        tick();
        check("clr.held", 64'(out_all), 64'd0);
        #2 clear = 1'b0;
        mem_ready = 1'b1;
        tick();
        check("clr.idle", 64'(out_all), 64'd0);
        kick();
        expect_outs("clr.restart_T0", 24'h100000, 16'h0, S_MAR | S_INC | S_Z, 4'd0, ST_B);
        cyc = 1;
        run_to_done(cyc);
        check("clr.restart_done_cycle", 64'(cyc), 64'd7);
        tick();

        // start held high: back-to-back sequences
        ir = mk_ir(5'd3, 4'd1, 4'd2, 4'd3);
        start = 1'b1;
        tick();
        drops = 0; ndone = 0; last_done = 0;
        for (int c = 1; c <= 21; c++) begin
            if (!busy) drops++;
            if (done) begin ndone++; last_done = c; end
            if (c == 8) check("b2b.T0_after_T5", 64'(bus_sel), 64'h100000);
            if (c == 21) start = 1'b0;
            tick();
        end
        check("b2b.busy_drops", 64'(drops), 64'd0);
        check("b2b.done_count", 64'(ndone), 64'd3);
        check("b2b.last_done", 64'(last_done), 64'd21);
        check("b2b.idle_after", 64'(busy), 64'd0);

        check("onehot_violations", 64'(onehot_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port clear, input, 1 bit: asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin a fetch/execute sequence when IDLE.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory read data valid this cycle.
REQ-005 SHALL have port ir, input, 32 bits: instruction register contents; opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
REQ-006 SHALL have port bus_sel, output, 24 bits: one-hot bus source select. Bits 0-15 are R0out-R15out; then HIout=16, LOout=17, ZHIout=18, ZLOout=19, PCout=20, MDRout=21, InPortOut=22, Cout=23.
REQ-007 SHALL have port r_in, output, 16 bits: register file load enables.
REQ-008 SHALL have ports pc_in, ir_in, mar_in, mdr_in, y_in, z_in, read, inc_pc, each output, 1 bit: datapath strobes.
REQ-009 SHALL have port alu_op, output, 4 bits: ALU function code (ir[30:27] minus 3).
REQ-010 SHALL have ports busy, done, illegal, each output, 1 bit: status.

Function
REQ-011 SHALL use states IDLE, T0, T1, MEMW, T2, T3, T4, T5; all outputs are Moore decodes of the registered state plus ir.
REQ-012 IDLE: all strobes 0; bus_sel=0; on start=1 go to T0 next edge.
REQ-013 T0: bus_sel[20], mar_in, inc_pc, z_in; go to T1.
REQ-014 T1: bus_sel[19], pc_in, read; go to MEMW.
REQ-015 MEMW: read=1; mdr_in=mem_ready; stay while mem_ready=0, go to T2 on mem_ready=1 (no timeout).
REQ-016 T2: bus_sel[21], ir_in; go to T3.
REQ-017 T3: if opcode not in 3..10 (add, sub, and, or, shr, shl, ror, rol), assert illegal for one cycle, drive no strobes, go to IDLE; else bus_sel[rb], y_in, go to T4.
REQ-018 T4: bus_sel[rc], alu_op valid, z_in; go to T5.
REQ-019 T5: bus_sel[19], r_in[ra]; done=1 this cycle; go to T0 if start=1 else IDLE.
REQ-020 alu_op SHALL be 0 outside T4.
REQ-021 bus_sel SHALL be zero or exactly one-hot in every cycle; r_in SHALL be zero or one-hot.
REQ-022 busy SHALL be 1 in every state except IDLE; start is ignored while busy, except in T5 (back-to-back).
REQ-023 Minimum latency start-to-done is 7 cycles (T0..T5 with mem_ready=1 on first MEMW cycle); each MEMW wait cycle adds one.
REQ-024 ir SHALL be sampled combinationally only in T3-T5; it is not registered internally.

Reset
REQ-025 clear=1 SHALL force IDLE immediately (asynchronous), from any state including MEMW mid-wait.
REQ-026 During and after reset, every output SHALL be 0 (bus_sel, r_in, strobes, alu_op, busy, done, illegal).
REQ-027 Leaving reset SHALL require start=1 on a clock edge before any strobe asserts.

Structure
REQ-028 Shared package SHALL hold the state enum, bus_sel bit indices (PC, ZLO, MDR, etc.), and opcode constants ADD=3 .. ROL=10.
REQ-029 A sub-module reg_decoder_4to16 (4-bit index plus enable to 16-bit one-hot) SHALL generate both r_in and the low 16 bits of bus_sel.
REQ-030 State register SHALL be the only sequential element besides nothing else; the implementation SHALL have no latches.

Verification
REQ-031 add R1,R2,R3 (opcode 3), mem_ready high: start pulse -> done at cycle 7; T3 bus_sel=0x000004, T4 bus_sel=0x000008 with alu_op=0, T5 r_in=0x0002.
REQ-032 mem_ready held low 5 cycles -> MEMW persists 5 cycles with read=1, mdr_in=0; mdr_in=1 only on the ready cycle; done at cycle 12.
REQ-033 opcode 15 -> illegal=1 in T3, no y_in/z_in/r_in, busy=0 next cycle.
REQ-034 clear asserted mid-MEMW -> all outputs 0 without a clock edge; a later start restarts at T0.
REQ-035 start held high continuously -> T5 followed directly by T0, with busy never deasserting.
REQ-036 All runs: assertion that popcount(bus_sel)<=1 and popcount(r_in)<=1 every cycle.
